// File: rtl/bitscan_seq.sv
`default_nettype none
// ============================================================================
// Module      : bitscan_seq
// Description : Sequential set-bit scanner. Accepts a WIDTH-bit mask over a
//               valid/ready handshake and streams the 1-based index of every
//               set bit, one index per output handshake. The scan order is
//               chosen per mask: lowest bit first or highest bit first. An
//               all-zero mask produces a single "none" beat with index 0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      mask width in bits (2..64)
//   IDX_W      index/count width, must hold 0..WIDTH
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   a mask is offered
//   in_ready   block can accept a mask (high only while idle)
//   in_data    mask to scan
//   in_dir     scan order sampled at accept (0 = lowest first, 1 = highest)
//   out_valid  out_idx / out_last are valid
//   out_ready  consumer takes the current beat
//   out_idx    1-based position of the current set bit, 0 for an empty mask
//   out_last   final beat of the current mask
//   busy       high while scanning
//   total      popcount of the accepted mask (0 unless POPCNT_EN is defined)
// Build options
//   POPCNT_EN  when defined, total is registered at accept with the
//              population count of in_data; otherwise total is tied to 0.
// ============================================================================
module bitscan_seq #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic [IDX_W-1:0] total
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nxt;
    logic             r_dir;
    logic             w_dir_nxt;

    // Priority-encoder results for the current mask
    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic [WIDTH-1:0] w_hi_bit;
    logic [WIDTH-1:0] w_lo_clr;
    logic [WIDTH-1:0] w_hi_clr;
    logic             w_scan;
    logic             w_single;

    // ------------------------------------------------------------------------
    // Lowest / highest set bit of r_mask.
    // The lowest-first loop runs downwards so the last hit is the lowest bit;
    // the highest-first loop runs upwards so the last hit is the highest bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_lo_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_lo_idx = IDX_W'(i + 1);
            end
        end
    end

    always_comb begin
        w_hi_idx = '0;
        w_hi_bit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_mask[i]) begin
                w_hi_idx    = IDX_W'(i + 1);
                w_hi_bit    = '0;
                w_hi_bit[i] = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit is the classic x & (x-1); the same term
    // being zero also tells us the mask has at most one set bit left.
    assign w_lo_clr = r_mask & (r_mask - c_one);
    assign w_hi_clr = r_mask & ~w_hi_bit;
    assign w_single = (w_lo_clr == '0);

    // ------------------------------------------------------------------------
    // Outputs. Index and last flag are combinational from the mask register;
    // they are gated by the state so that idle reads as zero.
    // ------------------------------------------------------------------------
    assign w_scan    = (r_state == ST_SCAN);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = w_scan;
    assign busy      = w_scan;
    assign out_idx   = w_scan ? (r_dir ? w_hi_idx : w_lo_idx) : '0;
    assign out_last  = w_scan & w_single;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_mask_nxt  = in_data;
                    w_dir_nxt   = in_dir;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    // An empty mask stays empty here, which is harmless
                    w_mask_nxt = r_dir ? w_hi_clr : w_lo_clr;
                    if (w_single) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Optional population count of the accepted mask
    // ------------------------------------------------------------------------
`ifdef POPCNT_EN
    logic             w_accept;
    logic [IDX_W-1:0] w_pop;
    logic [IDX_W-1:0] r_total;

    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{(IDX_W-1){1'b0}}, in_data[i]};
        end
    end

    // Held until the next accept, so it survives back-pressure and idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total <= '0;
        end else if (w_accept) begin
            r_total <= w_pop;
        end
    end

    assign total = r_total;
`else
    assign total = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitscan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitscan_seq
// Description : Self-checking bench for bitscan_seq (WIDTH=32 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitscan_seq;

    logic        clk;
    logic        reset;

    // WIDTH = 32 instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic [5:0]  total;

    // WIDTH = 8 instance
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        in_dir8;
    logic        out_valid8;
    logic        out_ready8;
    logic [3:0]  out_idx8;
    logic        out_last8;
    logic        busy8;
    logic [3:0]  total8;

    int n_chk;
    int n_fail;

    bitscan_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .total     (total)
    );

    bitscan_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_dir    (in_dir8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_idx   (out_idx8),
        .out_last  (out_last8),
        .busy      (busy8),
        .total     (total8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected total for a given popcount in the current build
    function automatic int exp_total(input int pop);
`ifdef POPCNT_EN
        return pop;
`else
        return 0;
`endif
    endfunction

    // ------------------------------------------------------------------------
    // Offer one mask to the 32-bit DUT, consume every beat with random
    // back-pressure and compare against a list-of-positions model.
    // ------------------------------------------------------------------------
    task automatic run32(input logic [31:0] m, input logic d, input int stall_pct,
                         output int nbeats, output int first_idx, output int final_idx);
        int q[$];
        int pop;
        int guard;
        bit rdy;
        q = {};
        for (int p = 0; p < 32; p++) begin
            if (m[p]) q.push_back(p + 1);
        end
        pop = q.size();
        if (d) q.reverse();
        if (q.size() == 0) q.push_back(0);

        nbeats    = 0;
        first_idx = -1;
        final_idx = -1;
        guard     = 0;

        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = m;
        in_dir   = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_dir   = 1'($urandom);

        while (q.size() > 0 && guard < 1000) begin
            chk("out_valid_scan", out_valid, 1);
            chk("in_ready_scan", in_ready, 0);
            chk("out_idx", out_idx, q[0]);
            chk("out_last", out_last, (q.size() == 1) ? 1 : 0);
            chk("total_scan", total, exp_total(pop));
            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                if (nbeats == 0) first_idx = q[0];
                final_idx = q[0];
                nbeats++;
                void'(q.pop_front());
            end
            guard++;
        end
        if (guard >= 1000) chk("beat_timeout", 0, 1);
        out_ready = 1'b1;
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("total_after", total, exp_total(pop));
    endtask

    typedef struct {
        logic [31:0] mask;
        logic        dir;
        int          beats;
        int          first;
        int          final_i;
        int          pop;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int nb, fi, la;
        logic [31:0] m;

        n_chk  = 0;
        n_fail = 0;
        tbl[0] = '{32'h0000_0000, 1'b0, 1, 0,  0,  0};
        tbl[1] = '{32'h8000_0005, 1'b0, 3, 1,  32, 3};
        tbl[2] = '{32'h8000_0005, 1'b1, 3, 32, 1,  3};
        tbl[3] = '{32'h0000_0001, 1'b1, 1, 1,  1,  1};
        tbl[4] = '{32'h4000_0000, 1'b0, 1, 31, 31, 1};

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_dir     = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = '0;
        in_dir8    = 1'b0;
        out_ready8 = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", total, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors, no back-pressure
        for (int i = 0; i < 5; i++) begin
            run32(tbl[i].mask, tbl[i].dir, 0, nb, fi, la);
            chk("tbl_beats", nb, tbl[i].beats);
            chk("tbl_first", fi, tbl[i].first);
            chk("tbl_final", la, tbl[i].final_i);
            chk("tbl_total", total, exp_total(tbl[i].pop));
        end

        // Back-pressure: 0x110 stalled 3 cycles
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0110;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_idx", out_idx, 5);
            chk("stall_last", out_last, 0);
            chk("stall_total", total, exp_total(2));
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("stall_rel_idx0", out_idx, 5);
        chk("stall_rel_last0", out_last, 0);
        @(negedge clk);
        chk("stall_rel_idx1", out_idx, 9);
        chk("stall_rel_last1", out_last, 1);
        @(negedge clk);
        chk("stall_done_valid", out_valid, 0);
        chk("stall_done_ready", in_ready, 1);

        // Reset mid-scan
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_dir   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            chk("pre_reset_idx", out_idx, b);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_total", total, 0);
        @(negedge clk);
        reset = 1'b1;
        run32(32'h0000_0002, 1'b0, 0, nb, fi, la);
        chk("postrst_beats", nb, 1);
        chk("postrst_idx", fi, 2);

        // WIDTH = 8: 0x80 with an ignored second offer during the scan
        @(negedge clk);
        in_valid8  = 1'b1;
        in_data8   = 8'h80;
        in_dir8    = 1'b0;
        out_ready8 = 1'b0;
        @(negedge clk);
        in_data8 = 8'hFF;
        chk("w8_in_ready_scan", in_ready8, 0);
        chk("w8_idx", out_idx8, 8);
        chk("w8_last", out_last8, 1);
        @(negedge clk);
        chk("w8_idx_hold", out_idx8, 8);
        out_ready8 = 1'b1;
        in_valid8  = 1'b0;
        @(negedge clk);
        chk("w8_valid_after", out_valid8, 0);
        chk("w8_ready_after", in_ready8, 1);
        // 0xFF offered from idle -> 1..8
        in_valid8 = 1'b1;
        in_data8  = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            chk("w8ff_valid", out_valid8, 1);
            chk("w8ff_idx", out_idx8, b);
            chk("w8ff_last", out_last8, (b == 8) ? 1 : 0);
            chk("w8ff_total", total8, exp_total(8));
            @(negedge clk);
        end
        chk("w8ff_done", out_valid8, 0);

        // Randomized masks against the model
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(3))
                0: m = $urandom;
                1: m = $urandom & $urandom & $urandom;
                2: begin m = '0; m[$urandom_range(31)] = 1'b1; end
                default: m = ($urandom_range(3) == 0) ? 32'h0 : ~($urandom & $urandom);
            endcase
            run32(m, 1'($urandom), 30, nb, fi, la);
            chk("rnd_beats", nb, (m == 0) ? 1 : $countones(m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bitscan_seq.md
# bitscan_seq

Sequential, parametrised set-bit scanner for the datapath's bit-manipulation unit. Accepts a WIDTH-bit mask over a valid/ready handshake and streams the 1-based index of every set bit, one index per output handshake. Scan order is lowest-first or highest-first, selected per mask. An all-zero mask produces a single "none" beat with index 0. Sits behind the ALU-side operand mux and feeds the writeback stage via its output handshake.

## Interface
- WIDTH, 32: mask width in bits; legal range 2..64.
- IDX_W, $clog2(WIDTH)+1: index and count width. Must hold values 0..WIDTH.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  a mask is offered.
- in_ready  out  1  block can accept a mask. High only in IDLE.
- in_data  in  WIDTH  mask to scan.
- in_dir  in  1  scan order, sampled at accept: 0 = lowest bit first, 1 = highest bit first.
- out_valid  out  1  out_idx / out_last are valid.
- out_ready  in  1  consumer takes the current beat.
- out_idx  out  IDX_W  1-based bit position (bit 0 → 1, bit WIDTH-1 → WIDTH); 0 means the mask was empty.
- out_last  out  1  final beat of the current mask.
- busy  out  1  high in SCAN.
- total  out  IDX_W  popcount of the accepted mask (see Configuration).

## Operation
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_data into mask_r, latch in_dir into dir_r, go to SCAN.
- SCAN:
  - out_valid=1.
  - out_idx = priority index of mask_r:
    - dir_r=0: lowest set bit.
    - dir_r=1: highest set bit.
    - mask_r==0: out_idx=0.
  - out_last=1 when mask_r has at most one set bit.
- On out_valid&&out_ready:
  - Clear the emitted bit from mask_r (dir 0: mask_r & (mask_r-1); dir 1: clear the highest set bit).
  - If out_last, go to IDLE.
- Empty mask: exactly one beat, out_idx=0, out_last=1.
- Mask with k>0 set bits: exactly k beats. No index beat is ever 0.
- in_valid during SCAN is ignored; in_ready=0. No overlap between masks.
- Index arithmetic is unsigned IDX_W bits; position p maps to p+1. No wrap is possible for legal WIDTH.

## Timing
- Reset values:
  - State IDLE, mask_r=0, dir_r=0.
  - out_valid=0, out_idx=0, out_last=0, busy=0, total=0.
  - in_ready=1 (inputs are ignored while reset is low).
- Accept at edge N → out_valid=1 and the first index valid in cycle N+1.
- Throughput: one index per cycle with out_ready held high.
- k-bit mask: last handshake at edge N+k. in_ready=1 in cycle N+k+1. Empty mask: last handshake at edge N+1.
- Back-pressure: while out_valid && !out_ready, out_idx, out_last, total and mask_r hold stable.
- Reset asserted mid-SCAN:
  - State, mask_r and all outputs clear immediately, not waiting for a clock edge.
  - The partially emitted mask is discarded.
  - The first edge after reset deassertion may accept a new mask.
- out_idx and out_last are combinational from mask_r and dir_r. All state is registered on clk.

## Configuration
- POPCNT_EN:
  - Defined: total is registered at accept with the population count of in_data, and held until the next accept.
  - Undefined: the popcount logic is absent and total is tied to 0.
  - The port list is identical in both builds.

## Test plan
- WIDTH=32, in_data=0x00000000, dir 0, out_ready=1 → one beat: idx 0, last 1. total 0. in_ready=1 two cycles after accept.
- in_data=0x80000005, dir 0, out_ready=1 → idx 1, 3, 32 on consecutive cycles, last only on 32. total=3 with POPCNT_EN, 0 without.
- Same mask with dir 1 → idx 32, 3, 1, last on 1.
- in_data=0x00000110, out_ready low for 3 cycles after out_valid rises:
  - idx stays 5, last 0, throughout the stall.
  - Then out_ready=1 → 5, then 9 with last 1.
- Reset mid-scan:
  - in_data=0xFFFFFFFF, dir 0. Pull reset low after 4 beats (idx 1..4).
  - out_valid drops with no clock edge, busy 0, in_ready 1.
  - After release, in_data=0x00000002 → single beat idx 2, last 1.
- WIDTH=8:
  - in_data=0x80, dir 0 → idx 8, last 1.
  - Second mask 0xFF offered on in_valid during that scan is ignored.
  - Offering 0xFF again after return to IDLE → idx 1..8.
